// File: rtl/tx_lane_pkg.sv
// Constants and state encoding shared by the transmit serializer and the
// receive-side block aligner.
package tx_lane_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCR_RST,
        HDR,
        PAYLOAD
    } tx_state_e;

    function automatic logic [1:0] sync_header(input logic ctrl);
        return ctrl ? HDR_CTRL : HDR_DATA;
    endfunction

endpackage

// File: rtl/tx_block_buffer.sv
// Single-entry holding register in front of the serializer; ready is a flop
// so upstream sees no combinational path from the serializer's load decision.
module tx_block_buffer
    import tx_lane_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_ctrl,
    input  logic              take,
    output logic              hold_full,
    output logic [DATA_W-1:0] hold_data,
    output logic              hold_ctrl
);

    logic accept;
    logic full_next;

    assign accept = s_valid && s_ready;

    // A take and an accept in the same cycle leave the buffer full with the new block.
    always_comb begin
        full_next = hold_full;
        if (take) begin
            full_next = 1'b0;
        end
        if (accept) begin
            full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            s_ready   <= 1'b0;
            hold_data <= '0;
            hold_ctrl <= 1'b0;
        end else begin
            hold_full <= full_next;
            s_ready   <= !full_next;
            if (accept) begin
                hold_data <= s_data;
                hold_ctrl <= s_ctrl;
            end
        end
    end

endmodule

// File: rtl/tx_block_serializer.sv
// Serializes 64-bit blocks behind a 2-bit sync header, one bit per clock, and
// drives the lane scrambler's data, enable and reseed inputs.
module tx_block_serializer
    import tx_lane_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_ctrl,
    input  logic              tx_en,
    input  logic              scr_rst_req,
    output logic              data_out,
    output logic              enable,
    output logic              hdr_bit,
    output logic              scr_rst,
    output logic              underflow
);

    tx_state_e         state;
    tx_state_e         state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              hdr_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [1:0]        hdr_q;
    logic              pending;
    logic              underflow_q;
    logic              take;
    logic              underflow_set;
    logic              last_bit;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              hold_ctrl;

    tx_block_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_ctrl    (s_ctrl),
        .take      (take),
        .hold_full (hold_full),
        .hold_data (hold_data),
        .hold_ctrl (hold_ctrl)
    );

    assign last_bit = (state == PAYLOAD) && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reseeds win over the next block so the scrambler only restarts between blocks.
    always_comb begin
        state_next    = state;
        take          = 1'b0;
        underflow_set = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = SCR_RST;
                end else if (hold_full && tx_en) begin
                    take       = 1'b1;
                    state_next = HDR;
                end
            end
            SCR_RST: begin
                state_next = IDLE;
            end
            HDR: begin
                if (hdr_cnt) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (last_bit) begin
                    if (pending) begin
                        state_next = SCR_RST;
                    end else if (hold_full && tx_en) begin
                        take       = 1'b1;
                        state_next = HDR;
                    end else begin
                        underflow_set = tx_en;
                        state_next    = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A request landing in the SCR_RST cycle itself must survive the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            hdr_cnt     <= 1'b0;
            shift_q     <= '0;
            hdr_q       <= 2'b00;
            pending     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pending     <= scr_rst_req || (pending && (state != SCR_RST));
            underflow_q <= underflow_set;
            hdr_cnt     <= (state == HDR) ? ~hdr_cnt : 1'b0;
            bit_cnt     <= ((state == PAYLOAD) && !last_bit) ? bit_cnt + 1'b1 : '0;
            if (take) begin
                shift_q <= hold_data;
                hdr_q   <= sync_header(hold_ctrl);
            end else if (state == PAYLOAD) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

    always_comb begin
        data_out  = 1'b0;
        enable    = 1'b0;
        hdr_bit   = 1'b0;
        scr_rst   = 1'b0;
        underflow = underflow_q;
        case (state)
            SCR_RST: begin
                scr_rst = 1'b1;
            end
            HDR: begin
                hdr_bit  = 1'b1;
                data_out = hdr_q[hdr_cnt];
            end
            PAYLOAD: begin
                enable   = 1'b1;
                data_out = shift_q[0];
            end
            default: begin
                data_out = 1'b0;
            end
        endcase
    end

endmodule
